smi_header_inject_pf1: RTL and testbench
========================================

SMI_HEADER_INJECT_PF1 -- requirements
Module: smiHeaderInjectPf1

Interface
REQ-001 SHALL have parameter FlitWidth, default 16: flit data width in bytes, integer power of two.
REQ-002 SHALL have parameter HeadWidth, default 4: header width in bytes, 1 <= HeadWidth < FlitWidth.
REQ-003 SHALL have parameter FlitSplit, default FlitWidth-HeadWidth: derived input/output byte split point.
REQ-004 SHALL have parameter EofcMask, default 2*FlitWidth-1: derived mask for unused end-of-frame control bits.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; there are no other clocks or resets.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 headerReady  input  1  header word valid.
REQ-009 headerData  input  HeadWidth*8  header to prepend; byte 0 in bits 7:0.
REQ-010 headerStop  output  1  header backpressure.
REQ-011 smiInReady  input  1  input flit valid.
REQ-012 smiInEofc  input  8  0 = mid-frame flit; 1..FlitWidth = last flit, valid byte count.
REQ-013 smiInData  input  FlitWidth*8  input flit payload.
REQ-014 smiInStop  output  1  input flit backpressure.
REQ-015 smiOutReady  output  1  output flit valid.
REQ-016 smiOutEofc  output  8  output end-of-frame control, same encoding as input.
REQ-017 smiOutData  output  FlitWidth*8  output flit payload.
REQ-018 smiOutStop  input  1  output backpressure.

Function
REQ-019 SHALL transfer on any link in a cycle where Ready=1 and Stop=0; Ready and its data SHALL remain stable while Stop=1.
REQ-020 SHALL register header and flit inputs in halting registers; headerStop and smiInStop SHALL be asserted only when the corresponding register is full and cannot advance.
REQ-021 SHALL AND the registered input eofc with EofcMask[7:0]; a masked value above FlitWidth is a protocol violation with unspecified output.
REQ-022 SHALL implement states Idle, CopyFrame and AddTail.
REQ-023 Idle: SHALL wait until both header and first flit registers are valid and the output accepts, then emit {in[FlitSplit*8-1:0], header}, saving in[FlitWidth*8-1:FlitSplit*8] and its eofc; the header and flit SHALL be consumed in the same cycle.
REQ-024 Idle exit: eofc=0 -> CopyFrame; 0<eofc<=FlitSplit -> emit with eofc+HeadWidth and remain Idle; eofc>FlitSplit -> emit with eofc 0, then AddTail.
REQ-025 CopyFrame: each accepted flit SHALL emit {in[FlitSplit*8-1:0], saved}, saving the new top HeadWidth bytes; eofc=0 -> remain; 0<eofc<=FlitSplit -> emit eofc+HeadWidth, go to Idle; eofc>FlitSplit -> emit eofc 0, go to AddTail.
REQ-026 AddTail: SHALL emit one flit with the saved bytes in bits HeadWidth*8-1:0, upper bytes don't-care, and eofc = savedEofc-FlitSplit; then go to Idle; no input is consumed in this state.
REQ-027 SHALL drive a one-entry output register slice; smiOutStop=1 SHALL hold it and stall the state machine with no loss or duplication.
REQ-028 Latency: with no backpressure, the first output flit SHALL be valid at smiOutReady 2 cycles after header and first flit are presented together.
REQ-029 Throughput: with no backpressure, one flit per cycle SHALL be sustained in CopyFrame; AddTail SHALL cost exactly one extra cycle.
REQ-030 A header arriving before its frame SHALL be held, stalling further headers; a frame arriving before its header SHALL be held.
REQ-031 Eofc arithmetic SHALL be 8-bit unsigned, with results always in 1..FlitWidth for legal inputs.

Reset
REQ-032 rst_n low SHALL immediately force the state to Idle and clear smiOutReady, the input-register valid flags, headerStop and smiInStop to 0.
REQ-033 Data registers (payload, saved bytes, saved eofc) SHALL NOT be reset.
REQ-034 Reset mid-frame SHALL discard the partial frame; the first frame after reset release SHALL be output correctly.

Verification (FlitWidth=16, HeadWidth=4)
REQ-035 Header 0xAABBCCDD, single flit eofc=8, bytes 0x00..0x07 -> one flit with eofc=12, bytes[3:0]=DD,CC,BB,AA and bytes[11:4]=00..07.
REQ-036 Single flit eofc=16, bytes 0x00..0x0F -> flit with eofc=0 and bytes[15:4]=00..0B, then flit with eofc=4 and bytes[3:0]=0C..0F.
REQ-037 Three-flit frame, last eofc=12 -> three output flits with eofc 0, 0, 16 and contiguous byte order.
REQ-038 smiOutStop held high for 5 cycles mid-frame -> smiInStop asserts, output is held stable, and the stream resumes with no gaps or duplicates.
REQ-039 rst_n pulsed low mid-frame -> smiOutReady is 0 in the same cycle; the next frame after release matches the REQ-035 response.
REQ-040 Header present 10 cycles before its frame, and a back-to-back second header -> headerStop holds the second header; both frames carry their correct headers.

Source files
------------

// File: rtl/smi_header_inject_pf1.sv
// smi_header_inject_pf1 -- prepends a HeadWidth-byte header to each SMI frame.
//
// Every output flit carries the low FlitSplit bytes of the current input flit
// above the HeadWidth bytes held over from the previous flit (the header on the
// first flit of a frame). When the last input flit has more than FlitSplit valid
// bytes, one extra tail flit is emitted to flush the held-over bytes.
//
// Handshake (all three links): a word moves in a cycle where Ready=1 and
// Stop=0. While Stop=1 the producer keeps Ready and its data stable.
//
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   headerReady/headerData/headerStop        header link (byte 0 in bits 7:0)
//   smiInReady/smiInEofc/smiInData/smiInStop input flit link
//   smiOutReady/smiOutEofc/smiOutData/smiOutStop output flit link
//   dbg_state                                current FSM state (0 Idle, 1 CopyFrame, 2 AddTail)
// Eofc: 0 = mid-frame flit, 1..FlitWidth = last flit with that many valid bytes.
module smi_header_inject_pf1 #(
  parameter int FlitWidth = 16,
  parameter int HeadWidth = 4,
  parameter int FlitSplit = FlitWidth - HeadWidth,
  parameter int EofcMask  = 2 * FlitWidth - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   headerReady,
  input  logic [HeadWidth*8-1:0] headerData,
  output logic                   headerStop,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COPY_FRAME = 2'd1,
    ADD_TAIL   = 2'd2
  } state_e;

  localparam logic [31:0] EOFC_MASK_W = EofcMask;
  localparam logic [7:0]  EOFC_MASK8  = EOFC_MASK_W[7:0];
  localparam logic [7:0]  SPLIT8      = 8'(FlitSplit);
  localparam logic [7:0]  HEAD8       = 8'(HeadWidth);

  state_e                 state_q, state_d;
  logic                   hdr_valid_q, hdr_valid_d;
  logic [HeadWidth*8-1:0] hdr_data_q, hdr_data_d;
  logic                   in_valid_q, in_valid_d;
  logic [7:0]             in_eofc_q, in_eofc_d;
  logic [FlitWidth*8-1:0] in_data_q, in_data_d;
  logic [HeadWidth*8-1:0] saved_q, saved_d;
  logic [7:0]             saved_eofc_q, saved_eofc_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_eofc_q, out_eofc_d;
  logic [FlitWidth*8-1:0] out_data_q, out_data_d;

  logic                   out_ok;
  logic                   fire;
  logic                   hdr_pop, in_pop;
  logic                   hdr_load, in_load;
  logic [7:0]             in_eofc_m;
  logic [HeadWidth*8-1:0] low_bytes;

  // The output slice can take a new flit when empty or being drained this cycle.
  assign out_ok    = !out_valid_q || !smiOutStop;
  assign in_eofc_m = in_eofc_q & EOFC_MASK8;

  // Input registers stall only when full and not being consumed this cycle.
  assign headerStop = hdr_valid_q && !hdr_pop;
  assign smiInStop  = in_valid_q && !in_pop;
  assign hdr_load   = headerReady && !headerStop;
  assign in_load    = smiInReady && !smiInStop;

  always_comb begin
    hdr_valid_d = hdr_load | (hdr_valid_q & ~hdr_pop);
    hdr_data_d  = hdr_load ? headerData : hdr_data_q;
    in_valid_d  = in_load | (in_valid_q & ~in_pop);
    in_data_d   = in_load ? smiInData : in_data_q;
    in_eofc_d   = in_load ? smiInEofc : in_eofc_q;
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_ok ? 1'b0 : out_valid_q;
    out_eofc_d   = out_eofc_q;
    out_data_d   = out_data_q;
    saved_d      = saved_q;
    saved_eofc_d = saved_eofc_q;
    hdr_pop      = 1'b0;
    in_pop       = 1'b0;
    fire         = 1'b0;
    low_bytes    = saved_q;

    case (state_q)
      IDLE: begin
        fire      = hdr_valid_q && in_valid_q && out_ok;
        hdr_pop   = fire;
        in_pop    = fire;
        low_bytes = hdr_data_q;
      end
      COPY_FRAME: begin
        fire   = in_valid_q && out_ok;
        in_pop = fire;
      end
      ADD_TAIL: begin
        if (out_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = {{(FlitSplit*8){1'b0}}, saved_q};
          out_eofc_d  = saved_eofc_q - SPLIT8;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared flit emission for Idle (header below) and CopyFrame (carry below).
    if (fire) begin
      out_valid_d  = 1'b1;
      out_data_d   = {in_data_q[FlitSplit*8-1:0], low_bytes};
      saved_d      = in_data_q[FlitWidth*8-1:FlitSplit*8];
      saved_eofc_d = in_eofc_m;
      if (in_eofc_m == 8'd0) begin
        out_eofc_d = 8'd0;
        state_d    = COPY_FRAME;
      end else if (in_eofc_m <= SPLIT8) begin
        out_eofc_d = in_eofc_m + HEAD8;
        state_d    = IDLE;
      end else begin
        // Carried bytes do not fit: close this flit and flush them next.
        out_eofc_d = 8'd0;
        state_d    = ADD_TAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hdr_valid_q <= 1'b0;
      in_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_valid_q <= hdr_valid_d;
      in_valid_q  <= in_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload registers carry no reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    hdr_data_q   <= hdr_data_d;
    in_data_q    <= in_data_d;
    in_eofc_q    <= in_eofc_d;
    saved_q      <= saved_d;
    saved_eofc_q <= saved_eofc_d;
    out_eofc_q   <= out_eofc_d;
    out_data_q   <= out_data_d;
  end

  assign smiOutReady = out_valid_q;
  assign smiOutEofc  = out_eofc_q;
  assign smiOutData  = out_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_smi_header_inject_pf1.sv
module tb_smi_header_inject_pf1;
  localparam int FW = 16;
  localparam int HW = 4;
  localparam int W  = FW * 8;

  logic          clk;
  logic          rst_n;
  logic          headerReady;
  logic [HW*8-1:0] headerData;
  logic          headerStop;
  logic          smiInReady;
  logic [7:0]    smiInEofc;
  logic [W-1:0]  smiInData;
  logic          smiInStop;
  logic          smiOutReady;
  logic [7:0]    smiOutEofc;
  logic [W-1:0]  smiOutData;
  logic          smiOutStop;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_eofc_q[$];
  logic [7:0]   cur_pl[$];

  int cyc = 0;
  int first_out_cyc = 0;
  int last_out_cyc  = 0;
  int out_count     = 0;
  bit mon_en     = 1'b1;
  bit rand_stop  = 1'b0;
  bit force_stop = 1'b0;

  smi_header_inject_pf1 #(.FlitWidth(FW), .HeadWidth(HW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .headerReady (headerReady),
    .headerData  (headerData),
    .headerStop  (headerStop),
    .smiInReady  (smiInReady),
    .smiInEofc   (smiInEofc),
    .smiInData   (smiInData),
    .smiInStop   (smiInStop),
    .smiOutReady (smiOutReady),
    .smiOutEofc  (smiOutEofc),
    .smiOutData  (smiOutData),
    .smiOutStop  (smiOutStop),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] byte_mask(input logic [7:0] e);
    logic [W-1:0] m;
    m = '0;
    if (e == 8'd0) m = '1;
    else for (int i = 0; i < FW; i++) if (i < e) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference: output frame = header bytes then payload, cut into FW-byte flits.
  task automatic push_expected(input logic [7:0] all_b[$]);
    int n;
    logic [W-1:0] d;
    int rem;
    n = all_b.size();
    for (int j = 0; j * FW < n; j++) begin
      d = '0;
      rem = n - j * FW;
      for (int b = 0; b < FW; b++) if (j * FW + b < n) d[b*8 +: 8] = all_b[j*FW+b];
      exp_q.push_back(d);
      exp_eofc_q.push_back(rem <= FW ? 8'(rem) : 8'd0);
    end
  endtask

  task automatic build_frame(input logic [HW*8-1:0] h, input int len, input bit seq);
    logic [7:0] all_b[$];
    cur_pl.delete();
    for (int i = 0; i < len; i++) cur_pl.push_back(seq ? 8'(i) : 8'($urandom_range(0, 255)));
    for (int k = 0; k < HW; k++) all_b.push_back(h[k*8 +: 8]);
    foreach (cur_pl[i]) all_b.push_back(cur_pl[i]);
    push_expected(all_b);
  endtask

  // ---------------- drivers (called at posedge+1, return at posedge+1) ----------------
  task automatic send_header(input logic [HW*8-1:0] h);
    bit took;
    int n;
    took = 1'b0;
    n = 0;
    headerReady = 1'b1;
    headerData  = h;
    while (!took) begin
      @(negedge clk);
      took = !headerStop;
      @(posedge clk); #1;
      n++;
      if (!took && n > 500) begin
        check("hdr_accept_timeout", took, 1);
        break;
      end
    end
    headerReady = 1'b0;
  endtask

  task automatic send_flits(input logic [7:0] pl[$]);
    int len;
    int rem;
    bit took;
    int n;
    logic [W-1:0] d;
    len = pl.size();
    for (int j = 0; j * FW < len; j++) begin
      d = '0;
      rem = len - j * FW;
      for (int b = 0; b < FW; b++) if (j * FW + b < len) d[b*8 +: 8] = pl[j*FW+b];
      smiInReady = 1'b1;
      smiInData  = d;
      smiInEofc  = (rem <= FW) ? 8'(rem) : 8'd0;
      took = 1'b0;
      n = 0;
      while (!took) begin
        @(negedge clk);
        took = !smiInStop;
        @(posedge clk); #1;
        n++;
        if (!took && n > 500) begin
          check("flit_accept_timeout", took, 1);
          break;
        end
      end
    end
    smiInReady = 1'b0;
  endtask

  task automatic send_frame(input logic [HW*8-1:0] h, input int len, input bit seq);
    logic [7:0] p[$];
    build_frame(h, len, seq);
    p = cur_pl;
    fork
      send_header(h);
      send_flits(p);
    join
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- output backpressure ----------------
  initial begin
    smiOutStop = 1'b0;
    forever begin
      @(posedge clk); #2;
      smiOutStop = force_stop || (rand_stop && ($urandom_range(0, 3) == 0));
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit held;
    logic [W-1:0] held_d;
    logic [7:0]   held_e;
    logic [W-1:0] ed;
    logic [7:0]   ee;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) held = 1'b0;
      else begin
        if (held) begin
          check("hold_valid", smiOutReady, 1);
          check("hold_data", smiOutData, held_d);
          check("hold_eofc", smiOutEofc, held_e);
        end
        if (smiOutReady && !smiOutStop) begin
          if (exp_q.size() == 0) check("unexpected_flit", exp_q.size(), 1);
          else begin
            ed = exp_q.pop_front();
            ee = exp_eofc_q.pop_front();
            check("out_eofc", smiOutEofc, ee);
            check("out_data", smiOutData & byte_mask(ee), ed);
          end
          if (out_count == 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
          out_count++;
          held = 1'b0;
        end else if (smiOutReady) begin
          held   = 1'b1;
          held_d = smiOutData;
          held_e = smiOutEofc;
        end else held = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    logic [HW*8-1:0] h1, h2;
    bit saw;

    rst_n = 1'b0;
    headerReady = 1'b0;
    headerData  = '0;
    smiInReady  = 1'b0;
    smiInEofc   = '0;
    smiInData   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_ready", smiOutReady, 0);
    check("rst_hdr_stop", headerStop, 0);
    check("rst_in_stop", smiInStop, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single short flit, and two-cycle latency from presentation to output.
    out_count = 0;
    fork
      send_frame(32'hAABBCCDD, 8, 1'b1);
      begin
        int l;
        l = 0;
        do begin
          @(posedge clk);
          l++;
          @(negedge clk);
        end while (!smiOutReady && l < 10);
        check("first_latency", l, 2);
      end
    join
    wait_drain();

    // Full 16-byte last flit: needs the tail flit, exactly one extra cycle.
    out_count = 0;
    send_frame(32'h11223344, 16, 1'b1);
    wait_drain();
    check("tail_cycles", last_out_cyc - first_out_cyc, 1);

    // Three-flit frame, last eofc 12: three back-to-back output flits.
    out_count = 0;
    send_frame(32'h55667788, 44, 1'b1);
    wait_drain();
    check("copy_flits", out_count, 3);
    check("copy_cycles", last_out_cyc - first_out_cyc, 2);

    // Five-cycle output stall mid-frame.
    out_count = 0;
    saw = 1'b0;
    fork
      send_frame(32'h0BADF00D, 90, 1'b0);
      begin
        int t;
        t = 0;
        while (out_count == 0 && t < 50) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk); #1;
        force_stop = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (smiInStop) saw = 1'b1;
          @(posedge clk); #1;
        end
        force_stop = 1'b0;
      end
    join
    check("stall_in_stop", saw, 1);
    wait_drain();

    // Reset pulsed mid-frame; partial frame discarded.
    mon_en = 1'b0;
    headerReady = 1'b1;
    headerData  = 32'hDEADBEEF;
    smiInReady  = 1'b1;
    smiInEofc   = 8'd0;
    smiInData   = {4{32'h01020304}};
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_ready", smiOutReady, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", smiOutReady, 0);
    check("mid_rst_in_stop", smiInStop, 0);
    check("mid_rst_hdr_stop", headerStop, 0);
    headerReady = 1'b0;
    smiInReady  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_eofc_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    send_frame(32'hAABBCCDD, 8, 1'b1);
    wait_drain();

    // Header ten cycles ahead of its frame; second header held behind it.
    h1 = 32'hCAFE0001;
    h2 = 32'hCAFE0002;
    build_frame(h1, 20, 1'b0);
    p1 = cur_pl;
    build_frame(h2, 7, 1'b0);
    p2 = cur_pl;
    send_header(h1);
    repeat (10) @(posedge clk);
    #1;
    check("early_hdr_held", headerStop, 1);
    check("early_no_output", smiOutReady, 0);
    fork
      send_header(h2);
      begin
        send_flits(p1);
        send_flits(p2);
      end
    join
    wait_drain();

    // Random frames under random output backpressure.
    rand_stop = 1'b1;
    for (int f = 0; f < 8; f++) send_frame(32'($urandom), $urandom_range(1, 50), 1'b0);
    wait_drain();
    rand_stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
